// File: rtl/ps_length_limiter.sv
// ps_length_limiter
// Caps packet length at MAXLEN words on a valid/ready packet stream.
// The data path is combinational (zero latency). A three-state FSM and a
// word counter decide which words pass and whether EOP has to be forced.
// Words after a forced EOP are dropped until the next SOP.
// Optional feature macro: PS_LENGTH_LIMITER_STAT_EN. When it is defined,
// o_trunc_cnt is a saturating count of truncated packets. When it is not
// defined, o_trunc_cnt is tied to zero.
module ps_length_limiter #(
  parameter int WIDTH  = 8,
  parameter int MAXLEN = 256,
  parameter int CNTW   = 16
) (
  input  logic             reset,
  input  logic             clk,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  input  logic             i_sop,
  input  logic             i_eop,
  output logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  output logic             o_sop,
  output logic             o_eop,
  input  logic             o_rdy,
  output logic             o_trunc,
  output logic [CNTW-1:0]  o_trunc_cnt
);

  localparam int CW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] MAX_K = CW'(MAXLEN);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] k;
  logic          pass_word;
  logic          at_max;

  // Classify the current word: it is passed if it opens a packet or continues one.
  always_comb begin
    pass_word = i_sop | (state == PASS);
    k         = i_sop ? CW'(1) : cnt + CW'(1);
    at_max    = (k == MAX_K);
  end

  assign o_dat   = i_dat;
  assign o_sop   = i_sop;
  assign o_val   = i_val & pass_word;
  assign i_rdy   = pass_word ? o_rdy : 1'b1;
  assign o_eop   = pass_word & (i_eop | at_max);
  assign o_trunc = o_val & o_rdy & ~i_eop & at_max;

  // Next-state and counter update. These change only when a word transfers.
  always_comb begin
    // NOTE: every signal driven here gets a default first. This keeps the block from inferring latches.
    state_nxt = state;
    cnt_nxt   = cnt;
    if (pass_word) begin
      if (o_val && o_rdy) begin
        if (i_eop) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (at_max) begin
          state_nxt = DROP;
          cnt_nxt   = '0;
        end else begin
          state_nxt = PASS;
          cnt_nxt   = k;
        end
      end
    end else if (i_val && (state == DROP) && i_eop) begin
      state_nxt = IDLE;
    end
  end

  // State and word-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register then samples pre-edge values.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PS_LENGTH_LIMITER_STAT_EN
  logic [CNTW-1:0] trunc_cnt;

  // Saturating count of truncated packets. It holds at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trunc_cnt <= '0;
    end else if (o_trunc && (trunc_cnt != '1)) begin
      trunc_cnt <= trunc_cnt + CNTW'(1);
    end
  end

  assign o_trunc_cnt = trunc_cnt;
`else
  assign o_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_ps_length_limiter.sv
// tb_ps_length_limiter
// Scoreboard bench for ps_length_limiter with MAXLEN=4 and CNTW=2. The
// narrow counter makes saturation reachable. Each word is run through a
// packet-level reference model when it is issued. The model pushes the
// expected output word, if any, into a queue. A monitor pops the queue and
// compares whenever the DUT presents a word.
module tb_ps_length_limiter;

  localparam int WIDTH  = 8;
  localparam int MAXLEN = 4;
  localparam int CNTW   = 2;

  logic             reset, clk;
  logic [WIDTH-1:0] i_dat;
  logic             i_val, i_sop, i_eop, i_rdy;
  logic [WIDTH-1:0] o_dat;
  logic             o_val, o_sop, o_eop, o_rdy, o_trunc;
  logic [CNTW-1:0]  o_trunc_cnt;

  ps_length_limiter #(.WIDTH(WIDTH), .MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .reset(reset), .clk(clk),
    .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_rdy(o_rdy),
    .o_trunc(o_trunc), .o_trunc_cnt(o_trunc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             sop;
    logic             eop;
    logic             trunc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;
  bit   tog      = 1'b0;

  // Packet-level reference: whether a packet is open and the 1-based position of the word in it.
  bit   active  = 1'b0;
  int   pos     = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt_out();
`ifdef PS_LENGTH_LIMITER_STAT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_word(input logic [WIDTH-1:0] d, input logic s, input logic e,
                            output bit passed);
    exp_t x;
    if (s) begin
      active = 1'b1;
      pos    = 1;
    end else if (active) begin
      pos++;
    end
    passed = active;
    if (passed) begin
      x.dat   = d;
      x.sop   = s;
      x.eop   = e | (pos == MAXLEN);
      x.trunc = !e && (pos == MAXLEN);
      exp_q.push_back(x);
      if (x.eop) active = 1'b0;
      if (x.trunc && exp_cnt < (1 << CNTW) - 1) exp_cnt++;
    end
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return tog;
  endfunction

  // Offer one word and hold it until the DUT accepts it. Mode 0 keeps o_rdy high, mode 1 randomizes it, mode 2 toggles it.
  task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic e, input int mode);
    bit passed, done;
    model_word(d, s, e, passed);
    i_val = 1'b1; i_dat = d; i_sop = s; i_eop = e;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      o_rdy = pick_rdy(mode);
      tog   = ~tog;
      @(negedge clk);
      check("i_rdy", i_rdy, passed ? o_rdy : 1'b1);
      done = i_rdy;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      o_rdy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int len, input bit term, input int mode);
    for (int i = 0; i < len; i++)
      send(8'($urandom), i == 0, term && (i == len - 1), mode);
  endtask

  task automatic do_reset();
    check("queue_empty_before_reset", exp_q.size(), 0);
    reset = 1'b1;
    active = 1'b0; pos = 0; exp_cnt = 0;
    @(negedge clk);
    check("rst_o_val", o_val, 0);
    check("rst_o_trunc", o_trunc, 0);
    check("rst_i_rdy", i_rdy, 1);
    check("rst_trunc_cnt", o_trunc_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_i_rdy", i_rdy, 1);
    check("post_rst_o_val", o_val, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    idle(3);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_trunc_cnt"}, o_trunc_cnt, exp_cnt_out());
  endtask

  // Monitor: compare every presented word with the scoreboard head and pop on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !reset) begin
      check("o_trunc_only_on_xfer", o_trunc & ~(o_val & o_rdy), 0);
      if (o_val) begin
        if (exp_q.size() == 0) begin
          check("unexpected_o_val", 1, 0);
        end else begin
          e = exp_q[0];
          check("o_dat", o_dat, e.dat);
          check("o_sop", o_sop, e.sop);
          check("o_eop", o_eop, e.eop);
          if (o_rdy) begin
            check("o_trunc", o_trunc, e.trunc);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_dat = '0; o_rdy = 1'b0;
    #12;
    mon_en = 1'b1;
    do_reset();

    // 3-word packet, no truncation.
    send_pkt(3, 1'b1, 0);
    check_drained("short_pkt");

    // 7-word packet: 4 words out with a forced EOP, and the rest dropped.
    send_pkt(7, 1'b1, 0);
    check_drained("long_pkt");

    // Exactly MAXLEN words with a real EOP, then a normal packet.
    send_pkt(4, 1'b1, 0);
    send_pkt(2, 1'b1, 0);
    check_drained("exact_pkt");

    // Unterminated 2-word packet, then a new SOP that restarts the count.
    send_pkt(2, 1'b0, 0);
    send_pkt(4, 1'b1, 0);
    check_drained("sop_restart");

    // 6-word packet with o_rdy toggling.
    send_pkt(6, 1'b1, 2);
    check_drained("toggle_rdy");

    // Stray words, a 1-word packet, then reset mid-packet and stray words again.
    send(8'hA1, 1'b0, 1'b0, 0);
    send(8'hA2, 1'b0, 1'b1, 0);
    send(8'h5C, 1'b1, 1'b1, 0);
    send_pkt(2, 1'b0, 1);
    do_reset();
    send(8'hB1, 1'b0, 1'b0, 1);
    send(8'hB2, 1'b0, 1'b1, 1);
    send_pkt(3, 1'b1, 1);
    check_drained("reset_mid_pkt");

    // Random traffic: stray words, terminated and unterminated packets, and varied o_rdy.
    for (int p = 0; p < 80; p++) begin
      int kind, mode, len;
      kind = $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      len  = $urandom_range(1, 8);
      if (kind == 0)      send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), mode);
      else if (kind == 1) send_pkt(len, 1'b0, mode);
      else                send_pkt(len, 1'b1, mode);
      idle($urandom_range(0, 2));
    end
    check_drained("random");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
